// File: rtl/top.sv
// Serial link trainer: PRBS7 per-lane transmit/check, DETECT/POLLING/L0
// link state machine, error counting and a registered LED status view.
module top #(
    parameter int    LINK_WIDTH    = 8,
    parameter string PL_FAST_TRAIN = "FALSE"
) (
    input  logic                  sys_clk_p,
    input  logic                  sys_clk_n,
    input  logic                  clk200_p,
    input  logic                  clk200_n,
    input  logic                  sys_rst_n,
    input  logic                  button_c,
    input  logic                  button_n,
    input  logic                  button_s,
    input  logic                  button_w,
    input  logic                  button_e,
    input  logic [3:0]            dipsw,
    output logic [7:0]            led,
    output logic [LINK_WIDTH-1:0] pci_exp_txp,
    output logic [LINK_WIDTH-1:0] pci_exp_txn,
    input  logic [LINK_WIDTH-1:0] pci_exp_rxp,
    input  logic [LINK_WIDTH-1:0] pci_exp_rxn
);

    localparam bit FAST       = (PL_FAST_TRAIN == "TRUE");
    localparam int DETECT_CYC = FAST ? 64 : 1024;
    localparam int LOCK_CNT   = FAST ? 32 : 256;
    localparam int POLL_TMO   = FAST ? 1024 : 16384;
    localparam int TW         = $clog2(POLL_TMO);
    localparam int GW         = $clog2(LOCK_CNT + 1);
    localparam int NL         = (LINK_WIDTH < 8) ? LINK_WIDTH : 8;

    typedef enum logic [1:0] {
        DETECT  = 2'd0,
        POLLING = 2'd1,
        L0      = 2'd2
    } state_t;

    logic                  clk;
    state_t                state;
    state_t                state_nxt;
    logic [TW-1:0]         timer;
    logic [TW-1:0]         timer_nxt;
    logic [2:0]            cons;
    logic [3:0]            err_cnt;
    logic [LINK_WIDTH-1:0] match;
    logic [LINK_WIDTH-1:0] locked;
    logic                  all_locked;
    logic                  err_cycle;
    logic [7:0]            led_nxt;
    logic                  unused;

    assign clk        = sys_clk_p;
    assign all_locked = &locked;
    assign err_cycle  = ~&match;
    assign unused     = ^{sys_clk_n, clk200_p, clk200_n, sys_rst_n,
                          button_w, button_e, dipsw[3:1]};

    for (genvar i = 0; i < LINK_WIDTH; i++) begin : g_lane
        localparam logic [6:0] SEED = 7'(i + 1);
        logic [6:0]    prbs;
        logic [6:0]    chk;
        logic [GW-1:0] good;
        logic          tx_p;
        logic          tx_n;
        logic          tx_bit;

        assign tx_bit         = prbs[6] ^ (button_n & (i == 0));
        assign match[i]       = (pci_exp_rxp[i] != pci_exp_rxn[i]) &&
                                (pci_exp_rxp[i] == (chk[6] ^ chk[5]));
        assign locked[i]      = (good == GW'(LOCK_CNT));
        assign pci_exp_txp[i] = tx_p;
        assign pci_exp_txn[i] = tx_n;

        // Lane generator, checker and good-run counter; DETECT idles the lane.
        always_ff @(posedge clk) begin
            if (button_c) begin
                prbs <= '0;
                chk  <= '0;
                good <= '0;
                tx_p <= 1'b0;
                tx_n <= 1'b0;
            end else if (state == DETECT) begin
                prbs <= SEED;
                chk  <= '0;
                good <= '0;
                tx_p <= 1'b0;
                tx_n <= 1'b0;
            end else begin
                prbs <= {prbs[5:0], prbs[6] ^ prbs[5]};
                chk  <= {chk[5:0], pci_exp_rxp[i]};
                if (!match[i])
                    good <= '0;
                else if (!locked[i])
                    good <= good + 1'b1;
                tx_p <= tx_bit;
                tx_n <= ~tx_bit;
            end
        end
    end

    // Link state transitions and the shared DETECT/POLLING timer.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer + 1'b1;
        unique case (state)
            DETECT: begin
                if (timer == TW'(DETECT_CYC - 1)) begin
                    state_nxt = POLLING;
                    timer_nxt = '0;
                end
            end
            POLLING: begin
                if (all_locked) begin
                    state_nxt = L0;
                    timer_nxt = '0;
                end else if (timer == TW'(POLL_TMO - 1)) begin
                    state_nxt = DETECT;
                    timer_nxt = '0;
                end
            end
            L0: begin
                timer_nxt = '0;
                if (err_cycle && cons == 3'd7)
                    state_nxt = DETECT;
            end
            default: begin
                state_nxt = DETECT;
                timer_nxt = '0;
            end
        endcase
    end

    // State register, consecutive-error run and sticky error counter.
    always_ff @(posedge clk) begin
        if (button_c) begin
            state   <= DETECT;
            timer   <= '0;
            cons    <= '0;
            err_cnt <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            if (state == L0 && err_cycle)
                cons <= cons + 1'b1;
            else
                cons <= '0;
            if (button_s)
                err_cnt <= '0;
            else if (state == L0 && err_cycle && err_cnt != 4'hF)
                err_cnt <= err_cnt + 1'b1;
        end
    end

    // LED view select: link state plus error count, or per-lane lock.
    always_comb begin
        led_nxt = '0;
        if (dipsw[0]) begin
            for (int k = 0; k < NL; k++)
                led_nxt[k] = locked[k];
        end else begin
            led_nxt = {err_cnt, 1'b0, state == DETECT,
                       state == POLLING, state == L0};
        end
    end

    // Registered LED output.
    always_ff @(posedge clk) begin
        if (button_c)
            led <= '0;
        else
            led <= led_nxt;
    end

endmodule

// File: tb/tb_top.sv
// Bench for top: randomized buttons/lane faults against a sequence-level
// reference model of training, PRBS checking and error counting.
module tb_top;

    localparam int W  = 8;
    localparam int DC = 64;
    localparam int LC = 32;
    localparam int PT = 1024;

    logic         sys_clk_p = 1'b0;
    logic         sys_clk_n;
    logic         clk200_p  = 1'b0;
    logic         clk200_n  = 1'b1;
    logic         sys_rst_n = 1'b1;
    logic         button_c  = 1'b1;
    logic         button_n  = 1'b0;
    logic         button_s  = 1'b0;
    logic         button_w  = 1'b0;
    logic         button_e  = 1'b0;
    logic [3:0]   dipsw     = 4'h0;
    logic [7:0]   led;
    logic [W-1:0] txp;
    logic [W-1:0] txn;
    logic [W-1:0] rxp       = '0;
    logic [W-1:0] rxn       = '0;

    assign sys_clk_n = ~sys_clk_p;
    always #5 sys_clk_p = ~sys_clk_p;

    top #(
        .LINK_WIDTH   (W),
        .PL_FAST_TRAIN("TRUE")
    ) dut (
        .sys_clk_p  (sys_clk_p),
        .sys_clk_n  (sys_clk_n),
        .clk200_p   (clk200_p),
        .clk200_n   (clk200_n),
        .sys_rst_n  (sys_rst_n),
        .button_c   (button_c),
        .button_n   (button_n),
        .button_s   (button_s),
        .button_w   (button_w),
        .button_e   (button_e),
        .dipsw      (dipsw),
        .led        (led),
        .pci_exp_txp(txp),
        .pci_exp_txn(txn),
        .pci_exp_rxp(rxp),
        .pci_exp_rxn(rxn)
    );

    int n_vec = 0;
    int n_bad = 0;

    // stimulus-side channel controls
    bit           conn_off = 1'b0;
    logic [W-1:0] flip     = '0;

    // reference model
    bit           gen[W][127];
    int           m_state;
    int           m_timer;
    int           m_cons;
    int           m_err;
    int           m_k;
    int           m_good[W];
    bit           m_hist[W][$];
    logic [W-1:0] m_txp;
    logic [W-1:0] m_txn;
    logic [7:0]   m_led;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic build_gen;
        for (int i = 0; i < W; i++) begin
            logic [6:0] sd;
            sd = 7'(i + 1);
            for (int j = 0; j < 7; j++)
                gen[i][j] = sd[6-j];
            for (int j = 7; j < 127; j++)
                gen[i][j] = gen[i][j-7] ^ gen[i][j-6];
        end
    endtask

    task automatic clear_hist(input int i);
        m_hist[i].delete();
        repeat (7) m_hist[i].push_back(1'b0);
    endtask

    task automatic model_reset;
        m_state = 0;
        m_timer = 0;
        m_cons  = 0;
        m_err   = 0;
        m_k     = 0;
        m_txp   = '0;
        m_txn   = '0;
        m_led   = '0;
        for (int i = 0; i < W; i++) begin
            m_good[i] = 0;
            clear_hist(i);
        end
    endtask

    task automatic model_step;
        bit           mt[W];
        logic [W-1:0] lk;
        bit           all_lk;
        bit           err_cyc;
        int           ns;
        if (button_c) begin
            model_reset();
            return;
        end
        all_lk  = 1'b1;
        err_cyc = 1'b0;
        for (int i = 0; i < W; i++) begin
            bit pred;
            pred  = m_hist[i][0] ^ m_hist[i][1];
            mt[i] = (rxp[i] != rxn[i]) && (rxp[i] == pred);
            lk[i] = (m_good[i] == LC);
            if (!lk[i])
                all_lk = 1'b0;
            if (!mt[i])
                err_cyc = 1'b1;
        end
        if (dipsw[0])
            m_led = lk;
        else
            m_led = {4'(m_err), 1'b0, m_state == 0, m_state == 1,
                     m_state == 2};
        for (int i = 0; i < W; i++) begin
            if (m_state == 0) begin
                clear_hist(i);
                m_good[i] = 0;
                m_txp[i]  = 1'b0;
                m_txn[i]  = 1'b0;
            end else begin
                bit b;
                m_hist[i].push_back(rxp[i]);
                void'(m_hist[i].pop_front());
                if (!mt[i])
                    m_good[i] = 0;
                else if (m_good[i] < LC)
                    m_good[i]++;
                b = gen[i][m_k % 127] ^ (button_n && i == 0);
                m_txp[i] = b;
                m_txn[i] = ~b;
            end
        end
        m_k = (m_state == 0) ? 0 : m_k + 1;
        if (button_s)
            m_err = 0;
        else if (m_state == 2 && err_cyc && m_err < 15)
            m_err++;
        ns = m_state;
        case (m_state)
            0: begin
                if (m_timer == DC - 1) begin
                    ns = 1;
                    m_timer = 0;
                end else
                    m_timer++;
            end
            1: begin
                if (all_lk) begin
                    ns = 2;
                    m_timer = 0;
                end else if (m_timer == PT - 1) begin
                    ns = 0;
                    m_timer = 0;
                end else
                    m_timer++;
            end
            default: begin
                if (err_cyc) begin
                    if (m_cons == 7)
                        ns = 0;
                    m_cons++;
                end else
                    m_cons = 0;
            end
        endcase
        if (m_state != 2)
            m_cons = 0;
        m_state = ns;
    endtask

    task automatic tick;
        if (conn_off) begin
            rxp = '0;
            rxn = '0;
        end else begin
            rxp = m_txp ^ flip;
            rxn = m_txn ^ flip;
        end
        @(posedge sys_clk_p);
        model_step();
        #1;
        check("led", 32'(led), 32'(m_led));
        check("txp", 32'(txp), 32'(m_txp));
        check("txn", 32'(txn), 32'(m_txn));
    endtask

    initial begin
        bit seen;
        int cnt;
        int inj_left;
        int off_left;
        logic prev2;
        build_gen();
        model_reset();

        // reset held, then released
        button_c = 1'b1;
        repeat (3) tick();
        check("rst_led", 32'(led), 32'h00);
        check("rst_tx", 32'({txp, txn}), 32'h0);
        button_c = 1'b0;
        tick();
        check("post_rst", 32'(led), 32'h04);

        // loopback training reaches L0 quickly
        seen = 1'b0;
        for (int c = 0; c < 150 && !seen; c++) begin
            tick();
            if (led == 8'h01)
                seen = 1'b1;
        end
        check("l0_by_150", 32'(seen), 32'h1);
        repeat (2000) tick();
        check("clean_l0", 32'(led), 32'h01);

        // single injected bit -> three error cycles
        button_n = 1'b1;
        tick();
        button_n = 1'b0;
        repeat (12) tick();
        check("inj1", 32'(led), 32'h31);
        button_s = 1'b1;
        tick();
        button_s = 1'b0;
        tick();
        check("clr", 32'(led), 32'h01);

        // per-lane lock view after lane 0 relocks
        repeat (40) tick();
        dipsw = 4'h1;
        tick();
        check("lock_view", 32'(led), 32'hFF);
        dipsw = 4'h0;
        tick();

        // long injection drops the link; it retrains afterwards
        seen = 1'b0;
        button_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (led[2])
                seen = 1'b1;
        end
        button_n = 1'b0;
        check("det_in_burst", 32'(seen), 32'h1);
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            tick();
            if (led[0])
                seen = 1'b1;
        end
        check("retrain", 32'(seen), 32'h1);

        // randomized buttons, lane faults, disconnects and resets
        inj_left = 0;
        off_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (inj_left > 0)
                inj_left--;
            else if ($urandom_range(0, 199) == 0)
                inj_left = $urandom_range(1, 20);
            button_n = (inj_left > 0);
            if (off_left > 0)
                off_left--;
            else if ($urandom_range(0, 999) == 0)
                off_left = $urandom_range(50, 1500);
            conn_off = (off_left > 0);
            button_s = ($urandom_range(0, 99) == 0);
            button_c = ($urandom_range(0, 1499) == 0);
            button_w = 1'($urandom);
            button_e = 1'($urandom);
            if ($urandom_range(0, 299) == 0)
                dipsw = 4'($urandom);
            flip = ($urandom_range(0, 299) == 0) ?
                   W'(1) << $urandom_range(0, W - 1) : '0;
            tick();
        end
        button_n = 1'b0;
        button_s = 1'b0;
        button_c = 1'b0;
        conn_off = 1'b0;
        flip     = '0;
        dipsw    = 4'h0;

        // dead channel: polling times out repeatedly, never L0
        button_c = 1'b1;
        tick();
        button_c = 1'b0;
        conn_off = 1'b1;
        cnt   = 0;
        seen  = 1'b0;
        prev2 = 1'b0;
        for (int c = 0; c < 2300; c++) begin
            tick();
            if (led[0])
                seen = 1'b1;
            if (led[2] && !prev2)
                cnt++;
            prev2 = led[2];
        end
        check("no_l0", 32'(seen), 32'h0);
        check("tmo_rise", 32'(cnt >= 3), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
